// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control unit: steps each instruction through
// fetch/decode/execute/memory/write-back and drives the datapath
// mux selects and write enables as Moore outputs.
module mc_ctrl_fsm #(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic [1:0]         RegDst,
  output logic               ALUSrc,
  output logic [1:0]         DatatoReg,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic [1:0]         PCSrc,
  output logic [1:0]         ExtOp,
  output logic [2:0]         ALUOp,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [STATE_W-1:0] {
    FETCH   = STATE_W'(0),
    DECODE  = STATE_W'(1),
    EXE_R   = STATE_W'(2),
    EXE_I   = STATE_W'(3),
    MEM_ADR = STATE_W'(4),
    MEM_RD  = STATE_W'(5),
    MEM_WR  = STATE_W'(6),
    WB_ALU  = STATE_W'(7),
    WB_MEM  = STATE_W'(8),
    BRANCH  = STATE_W'(9),
    JUMP    = STATE_W'(10)
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;

  state_t     state_q;
  state_t     state_d;
  logic [5:0] op_q;
  logic [5:0] fn_q;

  // State register; opcode/funct captured on leaving DECODE so later
  // states decode from a private copy rather than the live IR lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      op_q    <= '0;
      fn_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) begin
        op_q <= opcode;
        fn_q <= funct;
      end
    end
  end

  // Next-state selection; DECODE dispatches on the live IR fields.
  always_comb begin
    state_d = FETCH;
    unique case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        unique case (opcode)
          OP_RTYPE: begin
            if (funct == FN_ADDU || funct == FN_SUBU) state_d = EXE_R;
            else if (funct == FN_JR)                  state_d = JUMP;
            else                                      state_d = FETCH;
          end
          OP_ORI, OP_LUI: state_d = EXE_I;
          OP_LW, OP_SW:   state_d = MEM_ADR;
          OP_BEQ:         state_d = BRANCH;
          OP_J, OP_JAL:   state_d = JUMP;
          default:        state_d = FETCH;
        endcase
      end
      EXE_R, EXE_I: state_d = WB_ALU;
      MEM_ADR:      state_d = (op_q == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:       state_d = WB_MEM;
      default:      state_d = FETCH;
    endcase
  end

  // Moore outputs from state and latched fields; reset forces everything low.
  always_comb begin
    RegDst    = '0;
    ALUSrc    = 1'b0;
    DatatoReg = '0;
    RegWrite  = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCSrc     = '0;
    ExtOp     = '0;
    ALUOp     = ALU_ADD;
    if (!reset) begin
      unique case (state_q)
        FETCH: begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
        end
        EXE_R: begin
          ALUOp = (fn_q == FN_SUBU) ? ALU_SUB : ALU_ADD;
        end
        EXE_I: begin
          ALUSrc = 1'b1;
          ALUOp  = ALU_OR;
          ExtOp  = (op_q == OP_LUI) ? 2'b10 : 2'b00;
        end
        // ALU controls repeat the EXE values so the written result is stable.
        WB_ALU: begin
          RegWrite = 1'b1;
          if (op_q == OP_RTYPE) begin
            RegDst = 2'b01;
            ALUOp  = (fn_q == FN_SUBU) ? ALU_SUB : ALU_ADD;
          end else begin
            ALUSrc = 1'b1;
            ALUOp  = ALU_OR;
            ExtOp  = (op_q == OP_LUI) ? 2'b10 : 2'b00;
          end
        end
        MEM_ADR, MEM_RD: begin
          ALUSrc = 1'b1;
          ExtOp  = 2'b01;
        end
        MEM_WR: begin
          ALUSrc   = 1'b1;
          ExtOp    = 2'b01;
          MemWrite = 1'b1;
        end
        WB_MEM: begin
          RegWrite  = 1'b1;
          DatatoReg = 2'b01;
        end
        BRANCH: begin
          ALUOp   = ALU_SUB;
          ExtOp   = 2'b01;
          PCSrc   = 2'b01;
          PCWrite = zero;
        end
        JUMP: begin
          PCWrite = 1'b1;
          if (op_q == OP_RTYPE) begin
            PCSrc = 2'b11;
          end else begin
            PCSrc = 2'b10;
            if (op_q == OP_JAL) begin
              RegWrite  = 1'b1;
              RegDst    = 2'b10;
              DatatoReg = 2'b10;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: directed instruction set plus random instruction
// streams, checked cycle-by-cycle against an instruction-level model.
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic [1:0] RegDst;
  logic       ALUSrc;
  logic [1:0] DatatoReg;
  logic       RegWrite;
  logic       MemWrite;
  logic       IRWrite;
  logic       PCWrite;
  logic [1:0] PCSrc;
  logic [1:0] ExtOp;
  logic [2:0] ALUOp;
  logic [3:0] state;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  mc_ctrl_fsm #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .DatatoReg(DatatoReg),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .ExtOp(ExtOp), .ALUOp(ALUOp),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] r;
    logic        z;
  } cyc_t;

  cyc_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic logic [19:0] rec(input logic [3:0] st, input logic [1:0] rd,
      input logic as, input logic [1:0] dr, input logic rw, input logic mw,
      input logic irw, input logic pcw, input logic [1:0] ps,
      input logic [1:0] ext, input logic [2:0] ao);
    return {st, rd, as, dr, rw, mw, irw, pcw, ps, ext, ao};
  endfunction

  function automatic logic [19:0] observed();
    return {state, RegDst, ALUSrc, DatatoReg, RegWrite, MemWrite, IRWrite,
            PCWrite, PCSrc, ExtOp, ALUOp};
  endfunction

  function automatic string kind_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: begin
        if (fn == 6'b100001) return "addu";
        if (fn == 6'b100011) return "subu";
        if (fn == 6'b001000) return "jr";
        return "nop";
      end
      6'b001101: return "ori";
      6'b001111: return "lui";
      6'b100011: return "lw";
      6'b101011: return "sw";
      6'b000100: return "beq";
      6'b000010: return "j";
      6'b000011: return "jal";
      default:   return "nop";
    endcase
  endfunction

  function automatic void push(input logic [19:0] r, input logic z);
    cyc_t c;
    c.r = r;
    c.z = z;
    exp_q.push_back(c);
  endfunction

  // Expected per-cycle outputs for one instruction, from the instruction's
  // documented path and control values.
  function automatic void build(input string k, input logic zb);
    exp_q.delete();
    push(rec(4'd0, 2'd0, 0, 2'd0, 0, 0, 1, 1, 2'd0, 2'd0, 3'd0), 1'($urandom));
    push(rec(4'd1, 2'd0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 2'd0, 3'd0), 1'($urandom));
    case (k)
      "addu", "subu": begin
        logic [2:0] ao;
        ao = (k == "subu") ? 3'd1 : 3'd0;
        push(rec(4'd2, 2'd0, 0, 2'd0, 0, 0, 0, 0, 2'd0, 2'd0, ao), 1'($urandom));
        push(rec(4'd7, 2'd1, 0, 2'd0, 1, 0, 0, 0, 2'd0, 2'd0, ao), 1'($urandom));
      end
      "ori", "lui": begin
        logic [1:0] ext;
        ext = (k == "lui") ? 2'd2 : 2'd0;
        push(rec(4'd3, 2'd0, 1, 2'd0, 0, 0, 0, 0, 2'd0, ext, 3'd2), 1'($urandom));
        push(rec(4'd7, 2'd0, 1, 2'd0, 1, 0, 0, 0, 2'd0, ext, 3'd2), 1'($urandom));
      end
      "lw": begin
        push(rec(4'd4, 2'd0, 1, 2'd0, 0, 0, 0, 0, 2'd0, 2'd1, 3'd0), 1'($urandom));
        push(rec(4'd5, 2'd0, 1, 2'd0, 0, 0, 0, 0, 2'd0, 2'd1, 3'd0), 1'($urandom));
        push(rec(4'd8, 2'd0, 0, 2'd1, 1, 0, 0, 0, 2'd0, 2'd0, 3'd0), 1'($urandom));
      end
      "sw": begin
        push(rec(4'd4, 2'd0, 1, 2'd0, 0, 0, 0, 0, 2'd0, 2'd1, 3'd0), 1'($urandom));
        push(rec(4'd6, 2'd0, 1, 2'd0, 0, 1, 0, 0, 2'd0, 2'd1, 3'd0), 1'($urandom));
      end
      "beq":
        push(rec(4'd9, 2'd0, 0, 2'd0, 0, 0, 0, zb, 2'd1, 2'd1, 3'd1), zb);
      "j":
        push(rec(4'd10, 2'd0, 0, 2'd0, 0, 0, 0, 1, 2'd2, 2'd0, 3'd0), 1'($urandom));
      "jal":
        push(rec(4'd10, 2'd2, 0, 2'd2, 1, 0, 0, 1, 2'd2, 2'd0, 3'd0), 1'($urandom));
      "jr":
        push(rec(4'd10, 2'd0, 0, 2'd0, 0, 0, 0, 1, 2'd3, 2'd0, 3'd0), 1'($urandom));
      default: ;
    endcase
  endfunction

  // Entered at posedge+1 of a FETCH cycle; leaves at posedge+1 of the next one.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic zb);
    string k;
    logic [19:0] o;
    k = kind_of(op, fn);
    build(k, zb);
    opcode = op;
    funct  = fn;
    for (int i = 0; i < exp_q.size(); i++) begin
      zero = exp_q[i].z;
      #1;
      o = observed();
      check($sformatf("%s.c%0d.state", k, i), 32'(o[19:16]), 32'(exp_q[i].r[19:16]));
      check($sformatf("%s.c%0d.ctrl", k, i), 32'(o[15:0]), 32'(exp_q[i].r[15:0]));
      check($sformatf("%s.c%0d.rw_mw_excl", k, i), 32'(RegWrite & MemWrite), 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_cycles(input int unsigned n);
    reset = 1'b1;
    for (int unsigned i = 0; i < n; i++) begin
      #1;
      check($sformatf("rst.c%0d.ctrl", i), 32'(observed() & 20'h0FFFF), 32'd0);
      @(posedge clk);
      #1;
      check($sformatf("rst.c%0d.state", i), 32'(state), 32'd0);
    end
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] ops [10];
    logic [5:0] fns [10];
    reset  = 1'b1;
    opcode = '0;
    funct  = '0;
    zero   = 1'b0;
    @(posedge clk);
    #1;
    reset_cycles(3);

    // lw aborted by reset in MEM_RD: no WB_MEM write may follow.
    opcode = 6'b100011;
    funct  = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    check("lw_abort.pre_state", 32'(state), 32'd5);
    reset_cycles(3);
    #1;
    check("lw_abort.fetch_state", 32'(state), 32'd0);
    check("lw_abort.fetch_en", 32'({IRWrite, PCWrite, RegWrite}), 32'b110);

    // Directed instructions from the plan.
    run_instr(6'b000000, 6'b100001, 1'b0);
    run_instr(6'b000000, 6'b100011, 1'b0);
    run_instr(6'b100011, 6'b000000, 1'b0);
    run_instr(6'b101011, 6'b000000, 1'b0);
    run_instr(6'b000100, 6'b000000, 1'b1);
    run_instr(6'b000100, 6'b000000, 1'b0);
    run_instr(6'b000011, 6'b000000, 1'b0);
    run_instr(6'b000000, 6'b001000, 1'b0);
    run_instr(6'b000010, 6'b000000, 1'b0);
    run_instr(6'b001101, 6'b000000, 1'b0);
    run_instr(6'b001111, 6'b000000, 1'b0);
    run_instr(6'b111111, 6'b000000, 1'b0);
    run_instr(6'b000000, 6'b000000, 1'b0);

    // Random instruction stream, with occasional fully random encodings.
    ops = '{6'b000000, 6'b000000, 6'b000000, 6'b001101, 6'b001111,
            6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b000011};
    fns = '{6'b100001, 6'b100011, 6'b001000, 6'b0, 6'b0,
            6'b0, 6'b0, 6'b0, 6'b0, 6'b0};
    for (int n = 0; n < 300; n++) begin
      logic [5:0] op;
      logic [5:0] fn;
      int unsigned sel;
      sel = $urandom_range(0, 11);
      if (sel < 10) begin
        op = ops[sel];
        fn = (op == 6'b000000) ? fns[sel] : 6'($urandom);
      end else begin
        op = 6'($urandom);
        fn = 6'($urandom);
      end
      run_instr(op, fn, 1'($urandom));
      if ($urandom_range(0, 39) == 0) reset_cycles($urandom_range(1, 3));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
